apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
Synthesizable, parametrised APB4 requester. It converts a valid/ready command stream into APB transfers and replaces the fixed, single-peripheral bench requester. It decodes the address onto one of NUM_SLAVES PSEL lines. It checks alignment, enforces an access-phase timeout and returns a status-tagged response on a valid/ready response channel. It sits between an internal bus master and the APB peripheral fabric.

Parameters:
ADDR_WIDTH, 32, paddr/cmd_addr width
DATA_WIDTH, 32, pwdata/prdata width (multiple of 8; derived STRB_WIDTH = DATA_WIDTH/8, ALIGN_BITS = log2(STRB_WIDTH))
NUM_SLAVES, 4, number of PSEL outputs (1..16)
SLAVE_SHIFT, 12, slave index = cmd_addr >> SLAVE_SHIFT
TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with pready low before abort (>=1)

Ports:
clk  in  1  rising-edge clock (pclk)
reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  STRB_WIDTH  write byte strobes
cmd_prot  in  3  pprot value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 unless read with status OK)
rsp_status  out  2  00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
psel  out  NUM_SLAVES  one-hot select
penable  out  1  access phase
paddr  out  ADDR_WIDTH  registered address
pwrite  out  1  direction
pwdata  out  DATA_WIDTH  write data (0 on reads)
pstrb  out  STRB_WIDTH  strobes (0 on reads)
pprot  out  3  protection bits
prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
pready  in  NUM_SLAVES  per-slave ready
pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (sampled at posedge): state=IDLE. All outputs 0 except cmd_ready=1 in the cycle after reset. Timeout counter = 0.
- Reset mid-transfer: psel/penable drop on the next edge. Any held or in-flight response is discarded.
- cmd_ready = (state==IDLE). Only one transfer is outstanding at a time.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, command accepted:
  - if index >= NUM_SLAVES, or cmd_addr[ALIGN_BITS-1:0] != 0: go to RESP with status DECERR. No psel asserted; no bus activity.
  - otherwise: latch all command fields and the slave index, then go to SETUP.
- SETUP (1 cycle): psel[index]=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot driven from the latched command. Always advances to ACCESS.
- ACCESS: penable=1; all other bus outputs held stable. pready/pslverr/prdata are muxed by the latched index.
  - pready high: psel/penable go to 0 at that edge; go to RESP. Status = pslverr ? SLVERR : OK. rsp_rdata = prdata only for an OK read, else 0.
  - pready low: counter++. When the counter reaches TIMEOUT_CYCLES, go to RESP with status TIMEOUT and drop psel/penable.
  - pready high in the final permitted cycle completes normally; it is not a timeout.
- RESP: rsp_valid=1; rsp_rdata/rsp_status held stable until rsp_ready. The handshake returns to IDLE the next cycle.
- Minimum latency for a zero-wait transfer: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
- DECERR: rsp_valid in the cycle after acceptance.
- pstrb and pwdata are forced to 0 for reads. pprot is passed through unchanged.
- Counter width is clog2(TIMEOUT_CYCLES+1). The counter clears on entering SETUP.
- A peripheral asserting pready while not selected is ignored.

Test Plan:
- Write then read, NUM_SLAVES=4, cmd_addr=0x1004, wdata=0xFFFFFFFF, strb=4'hF, prot=3'b010, slave 1 zero-wait: psel=4'b0010 in cycles 1-2, penable only in cycle 2. Read returns 0xFFFFFFFF with status 00; rsp_valid arrives in cycle 3.
- Wait states: slave 0 holds pready low 3 cycles. Bus outputs stay stable throughout; response is OK at cycle 6; pstrb=0 on the read.
- Sparse write, strb=4'h1, wdata=0xFFFFFFFF to a location holding 0x12345600: read back 0x123456FF.
- Errors:
  - slave asserts pslverr with pready → status 01, rsp_rdata=0.
  - cmd_addr=0x4003 → status 10, psel never asserted.
  - cmd_addr=0x4000 with NUM_SLAVES=4 (index 4) → status 10.
- Timeout, TIMEOUT_CYCLES=16, pready tied low: psel/penable drop after 16 ACCESS cycles, status 11. Repeat with pready rising on the 16th cycle → status 00.
- Backpressure/reset: hold rsp_ready=0 for 5 cycles → response stable and cmd_ready=0. Assert reset during ACCESS → next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready command stream into single APB transfers
// with address decode, alignment check, access timeout and a status-tagged response.
module apb_requester #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SLAVE_SHIFT    = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [DATA_WIDTH-1:0]            cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
   input  logic [2:0]                       cmd_prot,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [1:0]                       rsp_status,
   output logic [NUM_SLAVES-1:0]            psel,
   output logic                             penable,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic                             pwrite,
   output logic [DATA_WIDTH-1:0]            pwdata,
   output logic [DATA_WIDTH/8-1:0]          pstrb,
   output logic [2:0]                       pprot,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
   localparam int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_SLVERR  = 2'b01;
   localparam logic [1:0] ST_DECERR  = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   strb_q, strb_d;
   logic [2:0]              prot_q, prot_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              status_q, status_d;

   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_WIDTH-1:0]   sel_rdata;
   logic                    dec_miss;
   logic                    misalign;

   // Only the latched slave's response lines matter; strays from others are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ready = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign dec_miss = (cmd_addr >> SLAVE_SHIFT) >= ADDR_WIDTH'(NUM_SLAVES);
   assign misalign = (cmd_addr & ALIGN_MASK) != '0;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      prot_d   = prot_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (dec_miss || misalign) begin
                  state_d  = RESP;
                  status_d = ST_DECERR;
                  rdata_d  = '0;
               end else begin
                  state_d = SETUP;
                  idx_d   = IDX_W'(cmd_addr >> SLAVE_SHIFT);
                  addr_d  = cmd_addr;
                  write_d = cmd_write;
                  wdata_d = cmd_write ? cmd_wdata : '0;
                  strb_d  = cmd_write ? cmd_strb : '0;
                  prot_d  = cmd_prot;
                  cnt_d   = '0;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            // A ready in the last permitted cycle wins over the timeout.
            if (sel_ready) begin
               state_d  = RESP;
               status_d = sel_err ? ST_SLVERR : ST_OK;
               rdata_d  = (!write_q && !sel_err) ? sel_rdata : '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d  = RESP;
                  status_d = ST_TIMEOUT;
                  rdata_d  = '0;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d  = IDLE;
               rdata_d  = '0;
               status_d = ST_OK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         prot_q   <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         status_q <= ST_OK;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         prot_q   <= prot_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
         assign psel[gi] = ((state_q == SETUP) || (state_q == ACCESS)) && (idx_q == IDX_W'(gi));
      end
   endgenerate

   assign cmd_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign rsp_rdata  = rdata_q;
   assign rsp_status = status_q;
   assign penable    = (state_q == ACCESS);
   assign paddr      = addr_q;
   assign pwrite     = write_q;
   assign pwdata     = wdata_q;
   assign pstrb      = strb_q;
   assign pprot      = prot_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: four memory-backed APB slaves with configurable
// wait states and error, and a scoreboard of expected responses.
module tb_apb_requester;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_write;
   logic [31:0]  cmd_addr;
   logic [31:0]  cmd_wdata;
   logic [3:0]   cmd_strb;
   logic [2:0]   cmd_prot;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_rdata;
   logic [1:0]   rsp_status;
   logic [3:0]   psel;
   logic         penable;
   logic [31:0]  paddr;
   logic         pwrite;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;
   logic [2:0]   pprot;
   logic [127:0] prdata;
   logic [3:0]   pready;
   logic [3:0]   pslverr;

   apb_requester #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4),
      .SLAVE_SHIFT(12), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   // Slave model
   logic [31:0] mem [4][16];
   int          wait_cfg = 0;
   int          acc_cnt  = 0;
   logic        err_cfg  = 1'b0;
   logic [3:0]  stray    = 4'b0000;

   always_comb begin
      pready  = '0;
      pslverr = '0;
      prdata  = '0;
      for (int i = 0; i < 4; i++) begin
         prdata[i*32 +: 32] = mem[i][paddr[5:2]];
         if (psel[i] && penable && (acc_cnt >= wait_cfg)) pready[i] = 1'b1;
         pslverr[i] = pready[i] & err_cfg;
      end
      pready = pready | stray;
   end

   always @(posedge clk) begin
      if (reset) begin
         acc_cnt <= 0;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) mem[i][j] <= '0;
      end else if ((psel != 4'b0) && penable) begin
         if ((psel & pready) != 4'b0) begin
            acc_cnt <= 0;
            for (int i = 0; i < 4; i++)
               if (psel[i] && pwrite && !err_cfg)
                  for (int b = 0; b < 4; b++)
                     if (pstrb[b]) mem[i][paddr[5:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
         end else begin
            acc_cnt <= acc_cnt + 1;
         end
      end else begin
         acc_cnt <= 0;
      end
   end

   typedef struct packed {
      logic [1:0]  status;
      logic [31:0] rdata;
   } rsp_t;
   rsp_t sb[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete transaction; called at posedge+1 with the DUT idle.
   task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      input logic [1:0] exp_status, input logic [31:0] exp_rdata,
                      input int exp_lat, input int hold);
      int   cycles;
      int   bus_bad;
      int   hold_bad;
      rsp_t exp_r;
      logic [3:0]  exp_sel;
      logic [1:0]  first_status;
      logic [31:0] first_rdata;
      exp_sel  = 4'b0001 << addr[13:12];
      bus_bad  = 0;
      hold_bad = 0;
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_wdata = wd;   cmd_strb = st;  cmd_prot = pr;
      sb.push_back('{status: exp_status, rdata: exp_rdata});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cycles = 1;
      while (!rsp_valid && cycles < 200) begin
         if (psel !== exp_sel) bus_bad++;
         if (penable !== (cycles >= 2)) bus_bad++;
         if (paddr !== addr || pwrite !== wr || pprot !== pr) bus_bad++;
         if (pwdata !== (wr ? wd : 32'h0) || pstrb !== (wr ? st : 4'h0)) bus_bad++;
         @(posedge clk); #1;
         cycles++;
      end
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_latency"}, cycles, exp_lat);
      check({tag, "_bus"}, bus_bad, 0);
      check({tag, "_idle_bus"}, {psel, penable}, 5'b0);
      first_status = rsp_status;
      first_rdata  = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (!rsp_valid || cmd_ready || rsp_status !== first_status || rsp_rdata !== first_rdata)
            hold_bad++;
      end
      if (hold > 0) check({tag, "_hold"}, hold_bad, 0);
      check({tag, "_sb_size"}, sb.size(), 1);
      if (sb.size() != 0) begin
         exp_r = sb.pop_front();
         check({tag, "_status"}, rsp_status, exp_r.status);
         check({tag, "_rdata"}, rsp_rdata, exp_r.rdata);
      end
      $display("txn %s: wr=%0d addr=%h status=%0d rdata=%h latency=%0d",
               tag, wr, addr, rsp_status, rsp_rdata, cycles);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "_rsp_done"}, rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_bus", {psel, penable, pwrite, pstrb, pprot}, 0);
      check("reset_paddr", paddr, 0);
      check("reset_pwdata", pwdata, 0);
      check("reset_rsp", {rsp_status, rsp_rdata}, 0);

      // Zero-wait write then read on slave 1
      run("wr_s1", 1, 32'h1004, 32'hFFFF_FFFF, 4'hF, 3'b010, 2'b00, 32'h0, 3, 0);
      run("rd_s1", 0, 32'h1004, 32'h0, 4'hF, 3'b010, 2'b00, 32'hFFFF_FFFF, 3, 0);

      // Wait states on slave 0, with a stray ready from unselected slave 2
      wait_cfg = 3; stray = 4'b0100;
      run("wr_s0_wait", 1, 32'h0008, 32'h1234_5600, 4'hF, 3'b001, 2'b00, 32'h0, 6, 0);
      stray = 4'b0000; wait_cfg = 0;
      run("wr_s0_sparse", 1, 32'h0008, 32'hFFFF_FFFF, 4'h1, 3'b000, 2'b00, 32'h0, 3, 0);
      wait_cfg = 3;
      run("rd_s0_wait", 0, 32'h0008, 32'hDEAD_BEEF, 4'hF, 3'b100, 2'b00, 32'h1234_56FF, 6, 0);
      wait_cfg = 0;

      // Slave error
      run("wr_s2", 1, 32'h2000, 32'hA5A5_A5A5, 4'hF, 3'b000, 2'b00, 32'h0, 3, 0);
      err_cfg = 1'b1;
      run("wr_s2_err", 1, 32'h2004, 32'h1111_1111, 4'hF, 3'b000, 2'b01, 32'h0, 3, 0);
      run("rd_s2_err", 0, 32'h2000, 32'h0, 4'h0, 3'b000, 2'b01, 32'h0, 3, 0);
      err_cfg = 1'b0;

      // Decode errors: misaligned and out-of-range slave index
      run("dec_misalign", 0, 32'h4003, 32'h0, 4'h0, 3'b000, 2'b10, 32'h0, 1, 0);
      run("dec_range", 0, 32'h4000, 32'h0, 4'h0, 3'b000, 2'b10, 32'h0, 1, 0);
      run("dec_misalign_wr", 1, 32'h1002, 32'h5555_5555, 4'hF, 3'b000, 2'b10, 32'h0, 1, 0);

      // Timeout, and completion on the final permitted cycle
      run("wr_s3", 1, 32'h3000, 32'hCAFE_0003, 4'hF, 3'b000, 2'b00, 32'h0, 3, 0);
      wait_cfg = 100;
      run("rd_s3_timeout", 0, 32'h3000, 32'h0, 4'h0, 3'b000, 2'b11, 32'h0, 18, 0);
      wait_cfg = 15;
      run("rd_s3_last", 0, 32'h3000, 32'h0, 4'h0, 3'b000, 2'b00, 32'hCAFE_0003, 18, 0);
      wait_cfg = 0;

      // Response backpressure
      run("rd_s1_bp", 0, 32'h1004, 32'h0, 4'h0, 3'b011, 2'b00, 32'hFFFF_FFFF, 3, 5);

      // Reset during ACCESS discards the transfer
      wait_cfg = 100;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000; cmd_prot = 3'b000;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_reset_in_access", {psel, penable}, 5'b0001_1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_reset_bus", {psel, penable}, 5'b0);
      check("mid_reset_rsp_valid", rsp_valid, 0);
      check("mid_reset_cmd_ready", cmd_ready, 1);
      $display("txn mid_reset: psel=%b penable=%0d rsp_valid=%0d cmd_ready=%0d",
               psel, penable, rsp_valid, cmd_ready);
      wait_cfg = 0;
      run("wr_after_reset", 1, 32'h2008, 32'h0BAD_F00D, 4'hF, 3'b111, 2'b00, 32'h0, 3, 0);
      run("rd_after_reset", 0, 32'h2008, 32'h0, 4'h0, 3'b111, 2'b00, 32'h0BAD_F00D, 3, 0);
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
